// File: rtl/pio_tx_fifo_pkg.sv
// pio_tx_fifo_pkg: default sizing constants shared by the PIO transmit FIFO, pio_core and pio_chip
package pio_tx_fifo_pkg;
   localparam int PIO_DATA_W     = 32;
   localparam int PIO_NUM_CORES  = 4;
   localparam int PIO_TXF_DEPTH  = 4;
   localparam int PIO_TXF_THRESH = 2;
endpackage

// File: rtl/pio_tx_fifo_if.sv
// pio_tx_fifo_if: producer/consumer bundle around the PIO transmit FIFO
//   master: drives wr_valid/wr_data (producer), pull (core), flush, clr_flags
//   slave : drives wr_ready, rd_data/rd_valid (show-ahead head), level, full, tx_req,
//           sticky overflow/underflow
interface pio_tx_fifo_if
   import pio_tx_fifo_pkg::*;
#(
   parameter int WIDTH = PIO_DATA_W,
   parameter int DEPTH = PIO_TXF_DEPTH
);
   logic                           wr_valid;
   logic [WIDTH-1:0]               wr_data;
   logic                           wr_ready;
   logic                           pull;
   logic [WIDTH-1:0]               rd_data;
   logic                           rd_valid;
   logic                           flush;
   logic                           clr_flags;
   logic [$clog2(DEPTH+1)-1:0]     level;
   logic                           full;
   logic                           tx_req;
   logic                           overflow;
   logic                           underflow;
   modport master (
      output wr_valid, wr_data, pull, flush, clr_flags,
      input  wr_ready, rd_data, rd_valid, level, full, tx_req, overflow, underflow
   );
   modport slave (
      input  wr_valid, wr_data, pull, flush, clr_flags,
      output wr_ready, rd_data, rd_valid, level, full, tx_req, overflow, underflow
   );
endinterface

// File: rtl/pio_tx_fifo.sv
// pio_tx_fifo: per-core show-ahead transmit FIFO feeding a pio_core
//   clk, rst : single rising-edge clock, synchronous active-high reset
//   bus      : pio_tx_fifo_if.slave (push side, pull side, flush, flags, level/status)
module pio_tx_fifo
   import pio_tx_fifo_pkg::*;
#(
   parameter int WIDTH  = PIO_DATA_W,
   parameter int DEPTH  = PIO_TXF_DEPTH,
   parameter int THRESH = PIO_TXF_THRESH
) (
   input  logic          clk,
   input  logic          rst,
   pio_tx_fifo_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [LW-1:0]    level;
   logic             full, empty, push, pop, set_ovf, set_unf;
   logic             overflow, underflow;
   // Handshake decisions use registered level only; flush masks every side effect.
   always_comb begin
      full    = level == LW'(DEPTH);
      empty   = level == '0;
      push    = bus.wr_valid && !full && !bus.flush;
      pop     = bus.pull && !empty && !bus.flush;
      set_ovf = bus.wr_valid && full && !bus.flush;
      set_unf = bus.pull && empty && !bus.flush;
   end
   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         level <= level + LW'(push) - LW'(pop);
      end
      // Flags survive flush; a new error wins over a same-cycle clear.
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= set_ovf || (overflow && !bus.clr_flags);
         underflow <= set_unf || (underflow && !bus.clr_flags);
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push) begin
         mem[wr_ptr] <= bus.wr_data;
      end
   end
   always_comb begin
      bus.rd_data   = mem[rd_ptr];
      bus.rd_valid  = !empty;
      bus.wr_ready  = !full;
      bus.full      = full;
      bus.level     = level;
      bus.tx_req    = level < LW'(THRESH);
      bus.overflow  = overflow;
      bus.underflow = underflow;
   end
endmodule

// File: tb/tb_pio_tx_fifo.sv
// tb_pio_tx_fifo: directed plus randomized checks of pio_tx_fifo against a queue-based model
module tb_pio_tx_fifo;
   localparam int DEPTH  = 4;
   localparam int THRESH = 2;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] q[$];
   bit   m_ovf = 1'b0;
   bit   m_unf = 1'b0;
   pio_tx_fifo_if #(.WIDTH(32), .DEPTH(DEPTH)) bus ();
   pio_tx_fifo #(.WIDTH(32), .DEPTH(DEPTH), .THRESH(THRESH)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic check_all();
      chk("level", 32'(bus.level), 32'(q.size()));
      chk("full", 32'(bus.full), 32'(q.size() == DEPTH));
      chk("wr_ready", 32'(bus.wr_ready), 32'(q.size() != DEPTH));
      chk("rd_valid", 32'(bus.rd_valid), 32'(q.size() != 0));
      chk("tx_req", 32'(bus.tx_req), 32'(q.size() < THRESH));
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
      chk("underflow", 32'(bus.underflow), 32'(m_unf));
      if (q.size() != 0) chk("rd_data", bus.rd_data, q[0]);
   endtask
   // One clock: drive inputs, advance the model on the edge, then compare.
   task automatic step(input bit r, input bit wv, input logic [31:0] wd, input bit pl,
                       input bit fl, input bit cf);
      bit was_full, was_empty, so, su;
      rst = r;
      bus.wr_valid = wv;
      bus.wr_data = wd;
      bus.pull = pl;
      bus.flush = fl;
      bus.clr_flags = cf;
      @(posedge clk);
      was_full = q.size() == DEPTH;
      was_empty = q.size() == 0;
      so = !fl && wv && was_full;
      su = !fl && pl && was_empty;
      if (r) begin
         q.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         if (fl) q.delete();
         else begin
            if (pl && !was_empty) void'(q.pop_front());
            if (wv && !was_full) q.push_back(wd);
         end
         m_ovf = so || (m_ovf && !cf);
         m_unf = su || (m_unf && !cf);
      end
      #1;
      check_all();
   endtask
   task automatic push(input logic [31:0] d);
      step(0, 1, d, 0, 0, 0);
   endtask
   task automatic pop();
      step(0, 0, 0, 1, 0, 0);
   endtask
   initial begin
      bus.wr_valid = 0;
      bus.wr_data = 0;
      bus.pull = 0;
      bus.flush = 0;
      bus.clr_flags = 0;
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      chk("rst_rd_data", bus.rd_data, 32'h0);
      chk("rst_tx_req", 32'(bus.tx_req), 32'd1);
      chk("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
      // fill
      for (int i = 1; i <= 4; i++) push(32'hA5A5_0000 + 32'(i));
      chk("fill_full", 32'(bus.full), 32'd1);
      chk("fill_level", 32'(bus.level), 32'd4);
      chk("fill_head", bus.rd_data, 32'hA5A5_0001);
      // drain in order
      for (int i = 1; i <= 4; i++) begin
         chk("drain_head", bus.rd_data, 32'hA5A5_0000 + 32'(i));
         pop();
      end
      chk("drain_valid", 32'(bus.rd_valid), 32'd0);
      chk("drain_unf", 32'(bus.underflow), 32'd0);
      // steady state at level 2 with pointer wrap
      push(32'h0000_2222);
      push(32'h0000_3333);
      for (int i = 0; i < 6; i++) step(0, 1, 32'h0000_1110 + 32'(i), 1, 0, 0);
      chk("steady_level", 32'(bus.level), 32'd2);
      chk("steady_head", bus.rd_data, 32'h0000_1114);
      // overflow while pulling from full
      push(32'h0000_0A0A);
      push(32'h0000_0B0B);
      step(0, 1, 32'h0000_DEAD, 1, 0, 0);
      chk("ovf_flag", 32'(bus.overflow), 32'd1);
      chk("ovf_level", 32'(bus.level), 32'd3);
      step(0, 0, 0, 0, 0, 1);
      chk("ovf_clr", 32'(bus.overflow), 32'd0);
      // underflow with simultaneous push into empty
      for (int i = 0; i < 3; i++) pop();
      step(0, 1, 32'h0000_BEEF, 1, 0, 0);
      chk("unf_flag", 32'(bus.underflow), 32'd1);
      chk("unf_level", 32'(bus.level), 32'd1);
      chk("unf_data", bus.rd_data, 32'h0000_BEEF);
      // clear racing a new error: set wins
      pop();
      step(0, 0, 0, 1, 0, 1);
      chk("set_wins", 32'(bus.underflow), 32'd1);
      // flush with push and pull pending
      push(32'h1);
      push(32'h2);
      push(32'h3);
      step(0, 1, 32'h4, 1, 1, 0);
      chk("flush_level", 32'(bus.level), 32'd0);
      chk("flush_valid", 32'(bus.rd_valid), 32'd0);
      chk("flush_txreq", 32'(bus.tx_req), 32'd1);
      chk("flush_flags", 32'(bus.underflow), 32'd1);
      // reset mid-push
      push(32'h5);
      push(32'h6);
      step(1, 1, 32'h7, 0, 0, 0);
      chk("mid_rst_rd_data", bus.rd_data, 32'h0);
      chk("mid_rst_level", 32'(bus.level), 32'd0);
      chk("mid_rst_unf", 32'(bus.underflow), 32'd0);
      // randomized traffic
      for (int n = 0; n < 600; n++)
         step($urandom_range(0, 149) == 0, $urandom_range(0, 9) < 6, $urandom,
              $urandom_range(0, 9) < 5, $urandom_range(0, 24) == 0,
              $urandom_range(0, 11) == 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
